// File: rtl/mem_pkg.sv
// Shared FSM encoding and default parameters for the memory requester and arbiter-side peers.
// Pure definitions; no timing or flow control of its own.
package mem_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 8;
  localparam int RD_LAT_DEF = 1;
  localparam int LAT_CNT_W  = 2;
  localparam int STALL_W    = 16;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_REQ  = 2'b01;
  localparam logic [1:0] ST_LAT  = 2'b10;
  localparam logic [1:0] ST_RESP = 2'b11;

  // Counter value on which the read data is due, counting from zero after the grant.
  function automatic logic [LAT_CNT_W-1:0] lat_last(input int rd_lat);
    return LAT_CNT_W'(rd_lat - 1);
  endfunction

endpackage

// File: rtl/mem_requester_if.sv
// Requester-to-arbiter bus: enables qualify addr/dout, acq grants, mem_din returns read data.
// The arbiter paces the requester only through acq.
interface mem_requester_if
  import mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic              mem_rden;
  logic              mem_wren;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_dout;
  logic              acq;
  logic [DATA_W-1:0] mem_din;

  modport master (
    output mem_rden, mem_wren, mem_addr, mem_dout,
    input  acq, mem_din
  );

  modport slave (
    input  mem_rden, mem_wren, mem_addr, mem_dout,
    output acq, mem_din
  );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter; one increment per edge with inc high, sticks at all-ones.
// No backpressure.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             CLK,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {WIDTH{1'b1}})) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/mem_requester.sv
// Single-outstanding memory requester: writes respond 1 cycle after grant, reads RD_LAT+1 cycles after.
// Accepts only in IDLE (req_ready); holds its bus request until the arbiter grants with acq.
module mem_requester
  import mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int RD_LAT = RD_LAT_DEF
) (
  input  logic               CLK,
  input  logic               rst,
  input  logic               req_rd,
  input  logic               req_wr,
  input  logic [ADDR_W-1:0]  req_addr,
  input  logic [DATA_W-1:0]  req_wdata,
  output logic               req_ready,
  output logic               rsp_valid,
  output logic [DATA_W-1:0]  rsp_rdata,
  output logic               busy,
  output logic [STALL_W-1:0] stall_cnt,
  mem_requester_if.master    mem_if
);

  logic [1:0]           state_q, state_d;
  logic                 op_wr_q, op_wr_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [DATA_W-1:0]    wdata_q, wdata_d;
  logic [DATA_W-1:0]    rdata_q, rdata_d;
  logic [LAT_CNT_W-1:0] lat_cnt_q, lat_cnt_d;
  logic                 in_req;

  always_comb begin
    state_d   = state_q;
    op_wr_d   = op_wr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    lat_cnt_d = lat_cnt_q;
    case (state_q)
      ST_IDLE: begin
        // A simultaneous read and write collapses to the write.
        if (req_rd || req_wr) begin
          state_d = ST_REQ;
          op_wr_d = req_wr;
          addr_d  = req_addr;
          wdata_d = req_wdata;
        end
      end
      ST_REQ: begin
        if (mem_if.acq) begin
          state_d   = op_wr_q ? ST_RESP : ST_LAT;
          lat_cnt_d = '0;
        end
      end
      ST_LAT: begin
        if (lat_cnt_q == lat_last(RD_LAT)) begin
          rdata_d = mem_if.mem_din;
          state_d = ST_RESP;
        end else begin
          lat_cnt_d = lat_cnt_q + 1'b1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      op_wr_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      lat_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      op_wr_q   <= op_wr_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      lat_cnt_q <= lat_cnt_d;
    end
  end

  assign in_req          = (state_q == ST_REQ);
  assign req_ready       = (state_q == ST_IDLE);
  assign busy            = (state_q != ST_IDLE);
  assign rsp_valid       = (state_q == ST_RESP);
  assign rsp_rdata       = rdata_q;
  assign mem_if.mem_rden = in_req && !op_wr_q;
  assign mem_if.mem_wren = in_req && op_wr_q;
  assign mem_if.mem_addr = addr_q;
  assign mem_if.mem_dout = wdata_q;

  sat_counter #(.WIDTH(STALL_W)) u_stall_cnt (
    .CLK   (CLK),
    .rst   (rst),
    .inc   (in_req && !mem_if.acq),
    .count (stall_cnt)
  );

endmodule

// File: tb/tb_mem_requester.sv
// Bench for mem_requester: vector table + scoreboard on an RD_LAT=1 instance,
// hand sequences for mid-transaction reset, stall saturation and RD_LAT=3.
module tb_mem_requester;

  typedef struct {
    logic       rd;
    logic       wr;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] din;
    int         gnt_dly;
    logic       exp_wr;
    logic [7:0] exp_rdata;
  } vec_t;

  logic CLK = 1'b0;
  logic rst;
  always #5 CLK = ~CLK;

  logic       rd1, wr1, ready1, rsp1, busy1;
  logic [7:0] addr1, wdata1, rdata1;
  logic [15:0] stall1;
  logic       rd3, wr3, ready3, rsp3, busy3;
  logic [7:0] addr3, wdata3, rdata3;
  logic [15:0] stall3;

  mem_requester_if #(.ADDR_W(8), .DATA_W(8)) if1 ();
  mem_requester_if #(.ADDR_W(8), .DATA_W(8)) if3 ();

  mem_requester #(.ADDR_W(8), .DATA_W(8), .RD_LAT(1)) dut1 (
    .CLK(CLK), .rst(rst), .req_rd(rd1), .req_wr(wr1), .req_addr(addr1), .req_wdata(wdata1),
    .req_ready(ready1), .rsp_valid(rsp1), .rsp_rdata(rdata1), .busy(busy1),
    .stall_cnt(stall1), .mem_if(if1)
  );

  mem_requester #(.ADDR_W(8), .DATA_W(8), .RD_LAT(3)) dut3 (
    .CLK(CLK), .rst(rst), .req_rd(rd3), .req_wr(wr3), .req_addr(addr3), .req_wdata(wdata3),
    .req_ready(ready3), .rsp_valid(rsp3), .rsp_rdata(rdata3), .busy(busy3),
    .stall_cnt(stall3), .mem_if(if3)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int exp_stall = 0;
  logic [7:0] sb[$];
  logic [7:0] sb_exp;
  vec_t vecs[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (rsp1 === 1'b1) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_rsp", rsp1, 0);
      end else begin
        sb_exp = sb.pop_front();
        chk("sb_rdata", rdata1, sb_exp);
      end
    end
  end

  // Called at a negedge with dut1 idle; returns at a negedge with dut1 idle again.
  task automatic run_txn(input vec_t v);
    rd1 = v.rd; wr1 = v.wr; addr1 = v.addr; wdata1 = v.wdata;
    if1.acq = 1'b0; if1.mem_din = ~v.din;
    chk("ready_before", ready1, 1);
    sb.push_back(v.exp_rdata);
    exp_stall = (exp_stall + v.gnt_dly > 16'hFFFF) ? 16'hFFFF : exp_stall + v.gnt_dly;
    @(negedge CLK);
    addr1 = ~v.addr; wdata1 = ~v.wdata;
    for (int c = 0; c <= v.gnt_dly; c++) begin
      chk("req_busy",  busy1, 1);
      chk("req_ready", ready1, 0);
      chk("req_wren",  if1.mem_wren, v.exp_wr);
      chk("req_rden",  if1.mem_rden, !v.exp_wr);
      chk("req_addr",  if1.mem_addr, v.addr);
      chk("req_dout",  if1.mem_dout, v.wdata);
      rd1 = (c < v.gnt_dly); wr1 = rd1;
      if (c == v.gnt_dly) if1.acq = 1'b1;
      @(negedge CLK);
    end
    if1.acq = 1'b0;
    chk("post_gnt_wren", if1.mem_wren, 0);
    chk("post_gnt_rden", if1.mem_rden, 0);
    if (!v.exp_wr) begin
      chk("lat_no_rsp", rsp1, 0);
      if1.mem_din = v.din;
      @(negedge CLK);
      if1.mem_din = ~v.din;
    end
    chk("rsp_valid", rsp1, 1);
    chk("rsp_rdata", rdata1, v.exp_rdata);
    chk("stall_cnt", stall1, exp_stall);
    @(negedge CLK);
    chk("rsp_pulse_end", rsp1, 0);
    chk("idle_ready", ready1, 1);
    chk("idle_busy", busy1, 0);
    chk("idle_addr_kept", if1.mem_addr, v.addr);
  endtask

  initial begin
    vecs[0] = '{1'b1, 1'b0, 8'h10, 8'h00, 8'hA5, 0, 1'b0, 8'hA5};
    vecs[1] = '{1'b0, 1'b1, 8'h22, 8'h5C, 8'h00, 3, 1'b1, 8'hA5};
    vecs[2] = '{1'b1, 1'b1, 8'h33, 8'h77, 8'h11, 1, 1'b1, 8'hA5};
    vecs[3] = '{1'b1, 1'b0, 8'hFF, 8'h00, 8'h3C, 2, 1'b0, 8'h3C};
    vecs[4] = '{1'b0, 1'b1, 8'h00, 8'hFF, 8'h00, 0, 1'b1, 8'h3C};
    vecs[5] = '{1'b1, 1'b0, 8'h80, 8'h00, 8'h5A, 5, 1'b0, 8'h5A};

    rd1 = 0; wr1 = 0; addr1 = 0; wdata1 = 0; if1.acq = 0; if1.mem_din = 0;
    rd3 = 0; wr3 = 0; addr3 = 0; wdata3 = 0; if3.acq = 0; if3.mem_din = 0;
    rst = 1'b1;
    #2 rst = 1'b0;
    #1;
    chk("rst_ready",  ready1, 1);
    chk("rst_rsp",    rsp1, 0);
    chk("rst_rdata",  rdata1, 0);
    chk("rst_busy",   busy1, 0);
    chk("rst_stall",  stall1, 0);
    chk("rst_rden",   if1.mem_rden, 0);
    chk("rst_wren",   if1.mem_wren, 0);
    chk("rst_addr",   if1.mem_addr, 0);
    chk("rst_dout",   if1.mem_dout, 0);
    chk("rst3_ready", ready3, 1);
    chk("rst3_stall", stall3, 0);
    repeat (2) @(negedge CLK);
    rst = 1'b1;

    foreach (vecs[i]) run_txn(vecs[i]);

    // Reset while in LAT with the grant still asserted.
    rd1 = 1; addr1 = 8'h6E; wdata1 = 8'h01; if1.acq = 1;
    @(negedge CLK);
    rd1 = 0;
    @(negedge CLK);
    chk("lat_busy", busy1, 1);
    chk("lat_rden", if1.mem_rden, 0);
    rst = 1'b0;
    if1.mem_din = 8'hEE;
    #1;
    chk("midrst_ready", ready1, 1);
    chk("midrst_rsp",   rsp1, 0);
    chk("midrst_rdata", rdata1, 0);
    chk("midrst_busy",  busy1, 0);
    chk("midrst_stall", stall1, 0);
    chk("midrst_rden",  if1.mem_rden, 0);
    chk("midrst_addr",  if1.mem_addr, 0);
    chk("midrst_dout",  if1.mem_dout, 0);
    exp_stall = 0;
    repeat (2) @(negedge CLK);
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      chk("postrst_no_rsp", rsp1, 0);
      chk("postrst_busy", busy1, 0);
      chk("postrst_ready", ready1, 1);
    end

    // First request is taken on the very first edge after release.
    rst = 1'b0;
    @(negedge CLK);
    rst = 1'b1;
    run_txn('{1'b0, 1'b1, 8'h9A, 8'h3E, 8'h00, 1, 1'b1, 8'h00});
    chk("sb_drained", sb.size(), 0);

    // Stall saturation and RD_LAT=3 on the second instance.
    rd3 = 1; addr3 = 8'h44; if3.mem_din = 8'h3C;
    @(negedge CLK);
    rd3 = 0;
    repeat (65540) @(negedge CLK);
    chk("sat_stall", stall3, 16'hFFFF);
    chk("sat_rden", if3.mem_rden, 1);
    chk("sat_addr", if3.mem_addr, 8'h44);
    repeat (10) @(negedge CLK);
    chk("sat_hold", stall3, 16'hFFFF);
    if3.acq = 1;
    @(negedge CLK);
    if3.acq = 0;
    chk("lat3_rden_off", if3.mem_rden, 0);
    chk("lat3_busy", busy3, 1);
    for (int k = 1; k <= 3; k++) begin
      if (k == 3) if3.mem_din = 8'hC3;
      @(negedge CLK);
      if3.mem_din = 8'h3C;
      chk("lat3_valid", rsp3, (k == 3));
    end
    chk("lat3_rdata", rdata3, 8'hC3);
    chk("lat3_stall", stall3, 16'hFFFF);
    @(negedge CLK);
    chk("lat3_pulse_end", rsp3, 0);
    chk("lat3_ready", ready3, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
